semaforo_monitor: RTL and testbench

Passive checker that sits on the lamp outputs of the traffic-light controller (`verde`, `amarelo`, `vermelho`) and reads them back.
- Decodes the lamps into a phase code and checks that exactly one lamp is lit.
- Checks the legal order vermelho → amarelo → verde → vermelho.
- Checks per-phase duration against `MIN_CYC` and `MAX_CYC`.
- Counts completed light cycles.

It is used in simulation benches and as an on-chip health monitor, and never drives the lamps.

---
 rtl/semaforo_monitor.sv | 177 +++++++++++++++++
 tb/tb_semaforo_monitor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/semaforo_monitor.sv
// semaforo_monitor: passive read-back checker for traffic-light lamp outputs.
// It decodes the lamps into a phase, checks that exactly one lamp is lit,
// checks the vermelho -> amarelo -> verde order and per-phase durations,
// and counts completed light cycles.
//
//   state | meaning
//   IDLE  | lamps dark or just invalid; waiting for a single lit lamp
//   SYNC  | phase known but its start time is not trusted; no timing checks
//   RUN   | legal sequence tracked; phase durations checked against MIN/MAX
module semaforo_monitor #(
    parameter int MIN_CYC   = 1,
    parameter int MAX_CYC   = 4,
    parameter int NBITS_CYC = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 verde,
    input  logic                 amarelo,
    input  logic                 vermelho,
    output logic [1:0]           phase,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [1:0]           err_code,
    output logic [2:0]           err_flags,
    output logic [NBITS_CYC-1:0] cycles
);

    localparam int DUR_W = $clog2(MAX_CYC + 2);
    localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);
    localparam logic [DUR_W-1:0] DUR_MIN = DUR_W'(MIN_CYC);
    localparam logic [DUR_W-1:0] DUR_MAX = DUR_W'(MAX_CYC);
    localparam logic [DUR_W-1:0] DUR_SAT = DUR_W'(MAX_CYC + 1);

    localparam logic [1:0] PH_DARK = 2'b00;
    localparam logic [1:0] PH_VERM = 2'b01;
    localparam logic [1:0] PH_AMAR = 2'b10;
    localparam logic [1:0] PH_VERD = 2'b11;

    localparam logic [1:0] EC_NONE   = 2'b00;
    localparam logic [1:0] EC_ONEHOT = 2'b01;
    localparam logic [1:0] EC_ORDER  = 2'b10;
    localparam logic [1:0] EC_TIMING = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SYNC = 2'b01,
        RUN  = 2'b10
    } state_t;

    state_t                r_state;
    logic [1:0]            r_phase;
    logic [DUR_W-1:0]      r_dur;
    logic                  r_err_pulse;
    logic [1:0]            r_err_code;
    logic [2:0]            r_err_flags;
    logic [NBITS_CYC-1:0]  r_cycles;

    state_t                w_state_nx;
    logic [1:0]            w_phase_nx;
    logic [DUR_W-1:0]      w_dur_nx;
    logic                  w_err_nx;
    logic [1:0]            w_code_nx;
    logic [NBITS_CYC-1:0]  w_cycles_nx;

    logic [1:0]            w_nlit;
    logic                  w_dark;
    logic                  w_multi;
    logic [1:0]            w_q;
    logic [1:0]            w_succ;

    // Lamp decode: lit count and phase code of the single lit lamp.
    always_comb begin
        w_nlit  = {1'b0, verde} + {1'b0, amarelo} + {1'b0, vermelho};
        w_dark  = (w_nlit == 2'd0);
        w_multi = (w_nlit >= 2'd2);
        w_q     = PH_DARK;
        if (vermelho)     w_q = PH_VERM;
        else if (amarelo) w_q = PH_AMAR;
        else if (verde)   w_q = PH_VERD;
        case (r_phase)
            PH_VERM: w_succ = PH_AMAR;
            PH_AMAR: w_succ = PH_VERD;
            PH_VERD: w_succ = PH_VERM;
            default: w_succ = PH_DARK;
        endcase
    end

    // Next-state, phase/duration tracking and error classification.
    // Branch order gives one-hot > order > timing priority for free.
    always_comb begin
        w_state_nx  = r_state;
        w_phase_nx  = r_phase;
        w_dur_nx    = r_dur;
        w_err_nx    = 1'b0;
        w_code_nx   = EC_NONE;
        w_cycles_nx = r_cycles;

        if (w_multi) begin
            w_err_nx   = 1'b1;
            w_code_nx  = EC_ONEHOT;
            w_state_nx = IDLE;
            w_phase_nx = PH_DARK;
            w_dur_nx   = '0;
        end else if (r_state == IDLE) begin
            if (!w_dark) begin
                w_state_nx = SYNC;
                w_phase_nx = w_q;
                w_dur_nx   = DUR_ONE;
            end
        end else if (w_dark) begin
            w_err_nx   = 1'b1;
            w_code_nx  = EC_ONEHOT;
            w_state_nx = IDLE;
            w_phase_nx = PH_DARK;
            w_dur_nx   = '0;
        end else if (w_q == r_phase) begin
            if (r_dur != DUR_SAT) begin
                w_dur_nx = r_dur + DUR_ONE;
            end
            // RUN never holds dur at saturation, so reaching MAX here is
            // the single over-long edge; phase and dur are kept in SYNC.
            if (r_state == RUN && r_dur == DUR_MAX) begin
                w_err_nx   = 1'b1;
                w_code_nx  = EC_TIMING;
                w_state_nx = SYNC;
            end
        end else if (w_q != w_succ) begin
            w_err_nx   = 1'b1;
            w_code_nx  = EC_ORDER;
            w_state_nx = SYNC;
            w_phase_nx = w_q;
            w_dur_nx   = DUR_ONE;
        end else begin
            if (r_state == RUN && r_dur < DUR_MIN) begin
                w_err_nx  = 1'b1;
                w_code_nx = EC_TIMING;
            end
            if (r_state == RUN && r_phase == PH_VERD) begin
                w_cycles_nx = r_cycles + NBITS_CYC'(1);
            end
            w_state_nx = RUN;
            w_phase_nx = w_q;
            w_dur_nx   = DUR_ONE;
        end
    end

    // State, tracking registers, error reporting and cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_phase     <= PH_DARK;
            r_dur       <= '0;
            r_err_pulse <= 1'b0;
            r_err_code  <= EC_NONE;
            r_err_flags <= 3'b000;
            r_cycles    <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_phase     <= w_phase_nx;
            r_dur       <= w_dur_nx;
            r_err_pulse <= w_err_nx;
            r_err_code  <= w_code_nx;
            r_cycles    <= w_cycles_nx;
            if (w_err_nx) begin
                r_err_flags[w_code_nx - 2'd1] <= 1'b1;
            end
        end
    end

    assign phase     = r_phase;
    assign locked    = (r_state == RUN);
    assign err_pulse = r_err_pulse;
    assign err_code  = r_err_code;
    assign err_flags = r_err_flags;
    assign cycles    = r_cycles;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed bench for semaforo_monitor: three instances share lamps and reset
// (defaults; MIN_CYC=2; NBITS_CYC=2) and each test checks the relevant one.
module tb_semaforo_monitor;

    localparam logic [2:0] L_D  = 3'b000;
    localparam logic [2:0] L_R  = 3'b001;
    localparam logic [2:0] L_A  = 3'b010;
    localparam logic [2:0] L_G  = 3'b100;
    localparam logic [2:0] L_AR = 3'b011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] lamps = L_D;

    logic [1:0] ph0, ec0, ph1, ec1, ph2, ec2;
    logic       lk0, ep0, lk1, ep1, lk2, ep2;
    logic [2:0] ef0, ef1, ef2;
    logic [7:0] cy0, cy1;
    logic [1:0] cy2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    semaforo_monitor #(.MIN_CYC(1), .MAX_CYC(4), .NBITS_CYC(8)) u_dut0 (
        .clk(clk), .reset(reset),
        .verde(lamps[2]), .amarelo(lamps[1]), .vermelho(lamps[0]),
        .phase(ph0), .locked(lk0), .err_pulse(ep0), .err_code(ec0),
        .err_flags(ef0), .cycles(cy0)
    );

    semaforo_monitor #(.MIN_CYC(2), .MAX_CYC(4), .NBITS_CYC(8)) u_dut1 (
        .clk(clk), .reset(reset),
        .verde(lamps[2]), .amarelo(lamps[1]), .vermelho(lamps[0]),
        .phase(ph1), .locked(lk1), .err_pulse(ep1), .err_code(ec1),
        .err_flags(ef1), .cycles(cy1)
    );

    semaforo_monitor #(.MIN_CYC(1), .MAX_CYC(4), .NBITS_CYC(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .verde(lamps[2]), .amarelo(lamps[1]), .vermelho(lamps[0]),
        .phase(ph2), .locked(lk2), .err_pulse(ep2), .err_code(ec2),
        .err_flags(ef2), .cycles(cy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply lamps/reset for one edge, then settle 1 time unit past it.
    task automatic step(input logic [2:0] l, input logic rst);
        lamps = l;
        reset = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(L_A, 1'b1);
        step(L_A, 1'b1);
    endtask

    initial begin
        // 1: reset defaults with lamps 010
        do_reset();
        check("rst_phase", 32'(ph0), 32'h0);
        check("rst_locked", 32'(lk0), 32'h0);
        check("rst_pulse", 32'(ep0), 32'h0);
        check("rst_code", 32'(ec0), 32'h0);
        check("rst_flags", 32'(ef0), 32'h0);
        check("rst_cycles", 32'(cy0), 32'h0);

        // 2: legal sequence R1 A1 G2, three times
        for (int k = 0; k < 3; k++) begin
            step(L_R, 1'b0);
            check("leg_phase_r", 32'(ph0), 32'h1);
            check("leg_cycles", 32'(cy0), 32'(k));
            step(L_A, 1'b0);
            check("leg_locked", 32'(lk0), 32'h1);
            step(L_G, 1'b0);
            step(L_G, 1'b0);
            check("leg_pulse", 32'(ep0), 32'h0);
        end
        check("leg_flags", 32'(ef0), 32'h0);

        // 3: order error, vermelho -> verde in RUN
        step(L_R, 1'b0);
        check("ord_cyc_pre", 32'(cy0), 32'h3);
        step(L_G, 1'b0);
        check("ord_pulse", 32'(ep0), 32'h1);
        check("ord_code", 32'(ec0), 32'h2);
        check("ord_flags", 32'(ef0), 32'h2);
        check("ord_locked", 32'(lk0), 32'h0);
        check("ord_phase", 32'(ph0), 32'h3);
        step(L_R, 1'b0);
        check("ord_relock", 32'(lk0), 32'h1);
        check("ord_pulse_off", 32'(ep0), 32'h0);
        check("ord_code_off", 32'(ec0), 32'h0);
        check("ord_cyc_sync", 32'(cy0), 32'h3);

        // 4a: verde held 5 cycles in RUN
        step(L_A, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(L_G, 1'b0);
            check("tmax_quiet", 32'(ep0), 32'h0);
        end
        step(L_G, 1'b0);
        check("tmax_pulse", 32'(ep0), 32'h1);
        check("tmax_code", 32'(ec0), 32'h3);
        check("tmax_flags", 32'(ef0), 32'h6);
        check("tmax_locked", 32'(lk0), 32'h0);
        step(L_G, 1'b0);
        check("tmax_once", 32'(ep0), 32'h0);
        step(L_R, 1'b0);
        check("tmax_recover", 32'(lk0), 32'h1);
        check("tmax_untimed", 32'(ep0), 32'h0);
        check("tmax_cyc", 32'(cy0), 32'h3);

        // 4b: MIN_CYC=2, amarelo held 1 cycle
        do_reset();
        step(L_R, 1'b0);
        step(L_A, 1'b0);
        step(L_A, 1'b0);
        step(L_G, 1'b0);
        step(L_G, 1'b0);
        step(L_R, 1'b0);
        step(L_R, 1'b0);
        step(L_A, 1'b0);
        check("tmin_quiet", 32'(ep1), 32'h0);
        step(L_G, 1'b0);
        check("tmin_pulse", 32'(ep1), 32'h1);
        check("tmin_code", 32'(ec1), 32'h3);
        check("tmin_locked", 32'(lk1), 32'h1);
        check("tmin_flags", 32'(ef1), 32'h4);
        check("tmin_phase", 32'(ph1), 32'h3);

        // 5: one-hot errors
        do_reset();
        step(L_R, 1'b0);
        step(L_A, 1'b0);
        step(L_AR, 1'b0);
        check("oh_pulse1", 32'(ep0), 32'h1);
        check("oh_code1", 32'(ec0), 32'h1);
        check("oh_phase1", 32'(ph0), 32'h0);
        check("oh_locked1", 32'(lk0), 32'h0);
        step(L_AR, 1'b0);
        check("oh_pulse2", 32'(ep0), 32'h1);
        check("oh_code2", 32'(ec0), 32'h1);
        step(L_D, 1'b0);
        check("oh_idle_dark", 32'(ep0), 32'h0);
        check("oh_flags", 32'(ef0), 32'h1);
        step(L_R, 1'b0);
        check("oh_sync_lock", 32'(lk0), 32'h0);
        check("oh_sync_phase", 32'(ph0), 32'h1);
        step(L_A, 1'b0);
        step(L_D, 1'b0);
        check("oh_dark_pulse", 32'(ep0), 32'h1);
        check("oh_dark_code", 32'(ec0), 32'h1);
        check("oh_dark_lock", 32'(lk0), 32'h0);
        check("oh_dark_phase", 32'(ph0), 32'h0);
        step(L_D, 1'b0);
        check("oh_dark_once", 32'(ep0), 32'h0);

        // 6: NBITS_CYC=2 wrap, then reset mid-verde
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(L_R, 1'b0);
            check("wrap_cycles", 32'(cy2), 32'(k % 4));
            step(L_A, 1'b0);
            step(L_G, 1'b0);
            step(L_G, 1'b0);
        end
        step(L_A, 1'b0);
        check("wrap_ord_flags", 32'(ef2), 32'h2);
        step(L_G, 1'b0);
        check("wrap_cyc_hold", 32'(cy2), 32'h1);
        step(L_G, 1'b1);
        check("mid_rst_cycles", 32'(cy2), 32'h0);
        check("mid_rst_flags", 32'(ef2), 32'h0);
        check("mid_rst_phase", 32'(ph2), 32'h0);
        check("mid_rst_locked", 32'(lk2), 32'h0);
        check("mid_rst_pulse", 32'(ep2), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
